// File: rtl/pc_update_unit.sv
// Control-flow resolution for call/ret/branch with a hardware return-address
// stack; emits a one-cycle PC_update pulse with the resolved fetch target.
module pc_update_unit #(
  parameter int PC_WIDTH    = 16,
  parameter int STACK_DEPTH = 16,
  parameter int BRANCH_WAIT = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                call,
  input  logic                ret,
  input  logic                branch,
  input  logic [PC_WIDTH-1:0] ID_PC,
  input  logic [PC_WIDTH-1:0] target,
  input  logic                cond_true,
  output logic                PC_update,
  output logic                PC_load,
  output logic [PC_WIDTH-1:0] new_PC,
  output logic                busy,
  output logic                stack_err
);

  localparam int AW  = $clog2(STACK_DEPTH);
  localparam int SPW = AW + 1;
  localparam int CW  = (BRANCH_WAIT > 1) ? $clog2(BRANCH_WAIT) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_UPDATE
  } state_t;

  typedef enum logic [1:0] {
    OP_CALL,
    OP_RET,
    OP_BR
  } op_t;

  state_t              state, state_n;
  op_t                 op, op_n;
  logic [CW-1:0]       cnt, cnt_n;
  logic [PC_WIDTH-1:0] pc_q, pc_n;
  logic [PC_WIDTH-1:0] tgt_q, tgt_n;
  logic                upd_n, load_n;
  logic [PC_WIDTH-1:0] npc_n;
  logic                push, pop;

  logic [PC_WIDTH-1:0] mem [STACK_DEPTH];
  logic [SPW-1:0]      sp;
  logic [AW-1:0]       wr_idx, rd_idx;
  logic                full, empty;
  logic [PC_WIDTH-1:0] ret_addr;

  assign wr_idx   = sp[AW-1:0];
  assign rd_idx   = wr_idx - 1'b1;
  assign full     = (sp == SPW'(STACK_DEPTH));
  assign empty    = (sp == '0);
  assign ret_addr = pc_q + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      op        <= OP_CALL;
      cnt       <= '0;
      pc_q      <= '0;
      tgt_q     <= '0;
      PC_update <= 1'b0;
      PC_load   <= 1'b0;
      new_PC    <= '0;
      busy      <= 1'b0;
    end else begin
      state     <= state_n;
      op        <= op_n;
      cnt       <= cnt_n;
      pc_q      <= pc_n;
      tgt_q     <= tgt_n;
      PC_update <= upd_n;
      PC_load   <= load_n;
      new_PC    <= npc_n;
      busy      <= (state_n != S_IDLE);
    end
  end

  always_comb begin
    state_n = state;
    op_n    = op;
    cnt_n   = cnt;
    pc_n    = pc_q;
    tgt_n   = tgt_q;
    upd_n   = 1'b0;
    load_n  = 1'b0;
    npc_n   = new_PC;
    push    = 1'b0;
    pop     = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (call) begin
          op_n    = OP_CALL;
          pc_n    = ID_PC;
          tgt_n   = target;
          state_n = S_UPDATE;
          upd_n   = 1'b1;
          load_n  = 1'b1;
          npc_n   = target;
        end else if (ret) begin
          op_n    = OP_RET;
          pc_n    = ID_PC;
          tgt_n   = target;
          state_n = S_UPDATE;
          upd_n   = 1'b1;
          load_n  = 1'b1;
          // Underflow falls back to the reset vector
          npc_n   = empty ? '0 : mem[rd_idx];
        end else if (branch) begin
          op_n    = OP_BR;
          pc_n    = ID_PC;
          tgt_n   = target;
          cnt_n   = CW'(BRANCH_WAIT - 1);
          state_n = S_WAIT;
        end
      end
      S_WAIT: begin
        if (cnt == '0) begin
          state_n = S_UPDATE;
          upd_n   = 1'b1;
          load_n  = cond_true;
          npc_n   = cond_true ? tgt_q : ret_addr;
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end
      S_UPDATE: begin
        state_n = S_IDLE;
        push    = (op == OP_CALL);
        pop     = (op == OP_RET);
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sp        <= '0;
      stack_err <= 1'b0;
    end else if (push) begin
      if (full) stack_err <= 1'b1;
      else      sp        <= sp + 1'b1;
    end else if (pop) begin
      if (empty) stack_err <= 1'b1;
      else       sp        <= sp - 1'b1;
    end
  end

  // Stack contents deliberately survive reset
  always_ff @(posedge clk) begin
    if (!rst && push && !full)
      mem[wr_idx] <= ret_addr;
  end

endmodule

// File: tb/tb_pc_update_unit.sv
// Directed bench for pc_update_unit: call/ret, branch timing, stack
// overflow/underflow, priority, PC wrap and reset abandonment.
module tb_pc_update_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        call, ret, branch;
  logic [15:0] ID_PC, target;
  logic        cond_true;
  logic        PC_update, PC_load;
  logic [15:0] new_PC;
  logic        busy, stack_err;

  int total = 0;
  int fails = 0;

  pc_update_unit #(
    .PC_WIDTH(16),
    .STACK_DEPTH(16),
    .BRANCH_WAIT(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .call(call),
    .ret(ret),
    .branch(branch),
    .ID_PC(ID_PC),
    .target(target),
    .cond_true(cond_true),
    .PC_update(PC_update),
    .PC_load(PC_load),
    .new_PC(new_PC),
    .busy(busy),
    .stack_err(stack_err)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic do_call(input logic [15:0] pc, input logic [15:0] tgt);
    call = 1'b1; ID_PC = pc; target = tgt;
    tick();
    call = 1'b0;
    chk("call_upd", PC_update, 1);
    chk("call_load", PC_load, 1);
    chk("call_npc", new_PC, tgt);
    tick();
    chk("call_done", PC_update, 0);
  endtask

  task automatic do_ret(input logic [15:0] exp);
    ret = 1'b1;
    tick();
    ret = 1'b0;
    chk("ret_upd", PC_update, 1);
    chk("ret_load", PC_load, 1);
    chk("ret_npc", new_PC, exp);
    tick();
    chk("ret_done", PC_update, 0);
  endtask

  task automatic do_branch(input logic c);
    branch = 1'b1; ID_PC = 16'h0040; target = 16'h0080;
    cond_true = ~c;
    tick();
    branch = 1'b0;
    chk("br_w1_upd", PC_update, 0);
    chk("br_w1_busy", busy, 1);
    tick();
    chk("br_w2_upd", PC_update, 0);
    cond_true = c;
    tick();
    cond_true = 1'b0;
    chk("br_upd", PC_update, 1);
    chk("br_load", PC_load, c);
    chk("br_npc", new_PC, c ? 16'h0080 : 16'h0041);
    tick();
    chk("br_done", PC_update, 0);
    chk("br_idle", busy, 0);
  endtask

  initial begin
    call = 0; ret = 0; branch = 0; cond_true = 0;
    ID_PC = '0; target = '0;
    do_reset();
    chk("rst_upd", PC_update, 0);
    chk("rst_load", PC_load, 0);
    chk("rst_npc", new_PC, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", stack_err, 0);

    do_call(16'h0010, 16'h0200);
    do_ret(16'h0011);
    chk("callret_err", stack_err, 0);

    do_branch(1'b1);
    do_branch(1'b0);

    // Stack empty again: underflow returns reset vector
    do_ret(16'h0000);
    chk("under_err", stack_err, 1);
    do_reset();
    chk("under_rst", stack_err, 0);

    for (int i = 0; i < 17; i++) begin
      do_call(16'h0100 + 16'(i), 16'h0300);
      if (i == 15) chk("ovf_16", stack_err, 0);
    end
    chk("ovf_17", stack_err, 1);
    for (int i = 15; i >= 0; i--)
      do_ret(16'h0101 + 16'(i));
    do_reset();

    call = 1'b1; branch = 1'b1;
    ID_PC = 16'h0020; target = 16'h0400;
    tick();
    call = 1'b0; branch = 1'b0;
    chk("pri_upd", PC_update, 1);
    chk("pri_npc", new_PC, 16'h0400);
    tick();
    chk("pri_idle", busy, 0);
    tick();
    chk("pri_nobr", PC_update, 0);
    do_ret(16'h0021);

    do_call(16'hFFFF, 16'h0500);
    do_ret(16'h0000);
    chk("wrap_err", stack_err, 0);

    branch = 1'b1; ID_PC = 16'h0040; target = 16'h0080;
    tick();
    branch = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rw_upd", PC_update, 0);
    chk("rw_busy", busy, 0);
    tick();
    chk("rw_upd2", PC_update, 0);
    tick();
    chk("rw_upd3", PC_update, 0);
    do_ret(16'h0000);
    chk("rw_sp0", stack_err, 1);
    do_reset();

    call = 1'b1; ID_PC = 16'h0070; target = 16'h0600;
    tick();
    call = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("ru_upd", PC_update, 0);
    do_ret(16'h0000);

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: run did not complete");
    $fatal(1, "timeout");
  end

endmodule
